// File: rtl/reduce_sweep_checker.sv
// rtl/reduce_sweep_checker.sv - stimulus sweep and golden-model checker for an N-input reduction DUT
// SWEEP_EXHAUSTIVE_EN selects the full 2**WIDTH sweep; default is the WIDTH+1 thermometer sweep.
module reduce_sweep_checker #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 5,
   parameter int OP     = 0,
`ifdef SWEEP_EXHAUSTIVE_EN
   localparam int NVEC  = 2 ** WIDTH,
`else
   localparam int NVEC  = WIDTH + 1,
`endif
   localparam int CNT_W = $clog2(NVEC + 1)
) (
   input  logic             clk,
   input  logic             global_resetn,
   input  logic             start,
   input  logic             dut_out,
   output logic [WIDTH-1:0] stim,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             first_fail_valid,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic             all_pass
);

   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int SET_W      = $clog2(SETTLE_EFF + 1);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_EFF - 1);
   localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NVEC - 1);
   localparam logic [CNT_W-1:0] NVEC_CNT    = CNT_W'(NVEC);

`ifdef SWEEP_EXHAUSTIVE_EN
   generate
      if (WIDTH > 16) begin : g_width_chk
         $error("reduce_sweep_checker: exhaustive sweep requires WIDTH <= 16");
      end
   endgenerate
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [WIDTH-1:0]   stim_q, stim_d;
   logic [CNT_W-1:0]   pass_q, pass_d;
   logic [CNT_W-1:0]   fail_q, fail_d;
   logic               ffv_q, ffv_d;
   logic [CNT_W-1:0]   ffi_q, ffi_d;
   logic               allp_q, allp_d;

   function automatic logic [WIDTH-1:0] pattern(input logic [CNT_W-1:0] i);
      logic [WIDTH-1:0] p;
`ifdef SWEEP_EXHAUSTIVE_EN
      p = WIDTH'(i);
`else
      p = '0;
      for (int b = 0; b < WIDTH; b++) begin
         p[b] = (CNT_W'(b) < i);
      end
`endif
      return p;
   endfunction

   // OP=3 (illegal) falls into the AND default on purpose.
   function automatic logic golden(input logic [WIDTH-1:0] s);
      logic g;
      case (OP)
         1:       g = |s;
         2:       g = ^s;
         default: g = &s;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk or negedge global_resetn) begin
      if (!global_resetn) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         stim_q   <= '0;
         pass_q   <= '0;
         fail_q   <= '0;
         ffv_q    <= 1'b0;
         ffi_q    <= '0;
         allp_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         stim_q   <= stim_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         ffv_q    <= ffv_d;
         ffi_q    <= ffi_d;
         allp_q   <= allp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      stim_d   = stim_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      ffv_d    = ffv_q;
      ffi_d    = ffi_q;
      allp_d   = allp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pass_d  = '0;
               fail_d  = '0;
               ffv_d   = 1'b0;
               ffi_d   = '0;
               allp_d  = 1'b0;
               idx_d   = '0;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            stim_d   = pattern(idx_q);
            settle_d = SETTLE_LOAD;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_CHECK;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         S_CHECK: begin
            // An X on dut_out makes the equality unknown, which takes the mismatch branch.
            if (dut_out == golden(stim_q)) begin
               pass_d = pass_q + CNT_W'(1);
            end else begin
               fail_d = fail_q + CNT_W'(1);
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + CNT_W'(1);
               state_d = S_DRIVE;
            end
         end
         S_DONE: begin
            allp_d  = (fail_q == '0) && (pass_q == NVEC_CNT);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stim             = stim_q;
   assign busy             = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done             = (state_q == S_DONE);
   assign pass_cnt         = pass_q;
   assign fail_cnt         = fail_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_idx   = ffi_q;
   assign all_pass         = allp_q;

endmodule
